// File: rtl/byte_unrotator_pipe_if.sv
// Valid/ready word stream carrying an N-byte word and its rotate amount.
// The master drives the word; the slave answers with ready.
interface byte_unrotator_pipe_if #(
  parameter int N = 16
);
  localparam int SW = $clog2(N);

  logic              valid;
  logic              ready;
  logic [8*N-1:0]    data;
  logic [SW-1:0]     amt;

  modport master (output valid, output data, output amt, input ready);
  modport slave  (input valid, input data, input amt, output ready);
endinterface

// File: rtl/byte_unrotator_pipe.sv
// Elastic log2(N)-stage byte-lane rotator toward lane 0; stage s rotates by 2^s lanes
// when amount bit s is set, so the chain as a whole undoes a forward rotation by k.
module byte_unrotator_pipe #(
  parameter int N = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  byte_unrotator_pipe_if.slave    in_if,
  byte_unrotator_pipe_if.master   out_if,
  output logic [$clog2(N):0]      occupancy
);
  localparam int SW = $clog2(N);

  logic [SW-1:0]   valid_q, valid_d;
  logic [8*N-1:0]  data_q [SW];
  logic [8*N-1:0]  data_d [SW];
  logic [SW-1:0]   amt_q  [SW];
  logic [SW-1:0]   amt_d  [SW];
  logic [SW:0]     occupancy_q, occupancy_d;
  logic [SW:0]     ready;
  logic            up_valid;
  logic [8*N-1:0]  up_data;
  logic [SW-1:0]   up_amt;

  function automatic logic [8*N-1:0] rot_down(input logic [8*N-1:0] d, input int sh);
    logic [8*N-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) begin
      r[8*j +: 8] = d[8*((j + sh) % N) +: 8];
    end
    return r;
  endfunction

  // Ready ripples back from the output so a full pipe still accepts when the sink drains.
  always_comb begin
    ready[SW] = out_if.ready;
    for (int s = SW - 1; s >= 0; s--) begin
      ready[s] = !valid_q[s] || ready[s+1];
    end

    valid_d     = valid_q;
    data_d      = data_q;
    amt_d       = amt_q;
    up_valid    = 1'b0;
    up_data     = '0;
    up_amt      = '0;
    occupancy_d = '0;

    for (int s = 0; s < SW; s++) begin
      if (s == 0) begin
        up_valid = in_if.valid;
        up_data  = in_if.data;
        up_amt   = in_if.amt;
      end else begin
        up_valid = valid_q[s-1];
        up_data  = data_q[s-1];
        up_amt   = amt_q[s-1];
      end
      if (ready[s]) begin
        valid_d[s] = up_valid;
        // Payload holds when a bubble moves in, so idle-cycle junk never enters the pipe.
        if (up_valid) begin
          data_d[s] = up_amt[s] ? rot_down(up_data, 1 << s) : up_data;
          amt_d[s]  = up_amt;
        end
      end
      occupancy_d = occupancy_d + (SW+1)'(valid_d[s]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      occupancy_q <= '0;
      for (int s = 0; s < SW; s++) begin
        data_q[s] <= '0;
        amt_q[s]  <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      occupancy_q <= occupancy_d;
      for (int s = 0; s < SW; s++) begin
        data_q[s] <= data_d[s];
        amt_q[s]  <= amt_d[s];
      end
    end
  end

  assign in_if.ready  = ready[0];
  assign out_if.valid = valid_q[SW-1];
  assign out_if.data  = data_q[SW-1];
  assign out_if.amt   = amt_q[SW-1];
  assign occupancy    = occupancy_q;
endmodule

// File: tb/tb_byte_unrotator_pipe.sv
// Self-checking bench for byte_unrotator_pipe: directed rotations, streaming,
// back-pressure, random round trip through a forward rotation, and mid-flight reset.
module tb_byte_unrotator_pipe;
  localparam int N  = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [SW:0]   occupancy;
  int            checkCount = 0;
  int            passCount = 0;

  byte_unrotator_pipe_if #(.N(N)) inBus ();
  byte_unrotator_pipe_if #(.N(N)) outBus ();

  byte_unrotator_pipe #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_if     (inBus),
    .out_if    (outBus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Output lane j holds input lane (j+k) mod 16.
  function automatic logic [127:0] refUnrotate(input logic [127:0] w, input int k);
    logic [7:0]   lanes [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) lanes[i] = w[8*i +: 8];
    for (int j = 0; j < 16; j++) r[8*j +: 8] = lanes[(j + k) % 16];
    return r;
  endfunction

  // Forward shifter: output lane j holds input lane (j-k) mod 16.
  function automatic logic [127:0] refRotate(input logic [127:0] w, input int k);
    logic [7:0]   lanes [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) lanes[i] = w[8*i +: 8];
    for (int j = 0; j < 16; j++) r[8*j +: 8] = lanes[(j - k + 16) % 16];
    return r;
  endfunction

  function automatic logic [127:0] randWord();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    inBus.valid = 1'b0;
    inBus.data  = randWord();
    inBus.amt   = 4'($urandom);
  endtask

  // Pushes one word into an empty pipe and waits (bounded) for it at the output.
  task automatic sendOne(input logic [127:0] w, input logic [3:0] k,
                         output logic [127:0] got, output logic [3:0] gotAmt, output int lat);
    outBus.ready = 1'b1;
    inBus.valid  = 1'b1;
    inBus.data   = w;
    inBus.amt    = k;
    cycle();
    idleInputs();
    lat = -1;
    got = '0;
    gotAmt = '0;
    for (int e = 0; e < 20; e++) begin
      if (outBus.valid) begin
        lat = e + 1;
        got = outBus.data;
        gotAmt = outBus.amt;
        break;
      end
      cycle();
    end
    cycle();
  endtask

  task automatic test_reset();
    idleInputs();
    outBus.ready = 1'b0;
    reset = 1'b1;
    repeat (3) cycle();
    checkCount++;
    if (outBus.valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", outBus.valid);
    else passCount++;
    checkCount++;
    if (outBus.data !== '0) $display("[TB] FAIL reset_out_data: got %h expected 0", outBus.data);
    else passCount++;
    checkCount++;
    if (outBus.amt !== '0) $display("[TB] FAIL reset_out_amt: got %h expected 0", outBus.amt);
    else passCount++;
    checkCount++;
    if (occupancy !== '0) $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy);
    else passCount++;
    reset = 1'b0;
    #1;
    checkCount++;
    if (inBus.ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", inBus.ready);
    else passCount++;
  endtask

  task automatic test_basic_rotate();
    logic [127:0] w, got;
    logic [3:0]   gotAmt;
    int           lat;
    for (int i = 0; i < 16; i++) w[8*i +: 8] = 8'(i);
    sendOne(w, 4'd3, got, gotAmt, lat);
    checkCount++;
    if (lat !== 4) $display("[TB] FAIL basic_latency: got %0d expected 4", lat);
    else passCount++;
    checkCount++;
    if (got !== refUnrotate(w, 3)) $display("[TB] FAIL basic_word: got %h expected %h", got, refUnrotate(w, 3));
    else passCount++;
    checkCount++;
    if (got[7:0] !== 8'h03) $display("[TB] FAIL basic_lane0: got %h expected 03", got[7:0]);
    else passCount++;
    checkCount++;
    if (got[8*12 +: 8] !== 8'h0F) $display("[TB] FAIL basic_lane12: got %h expected 0f", got[8*12 +: 8]);
    else passCount++;
    checkCount++;
    if (got[8*13 +: 8] !== 8'h00) $display("[TB] FAIL basic_lane13: got %h expected 00", got[8*13 +: 8]);
    else passCount++;
    checkCount++;
    if (got[8*15 +: 8] !== 8'h02) $display("[TB] FAIL basic_lane15: got %h expected 02", got[8*15 +: 8]);
    else passCount++;
    checkCount++;
    if (gotAmt !== 4'd3) $display("[TB] FAIL basic_amt: got %0d expected 3", gotAmt);
    else passCount++;
    checkCount++;
    if (outBus.valid !== 1'b0 || occupancy !== '0)
      $display("[TB] FAIL basic_drained: got valid=%b occ=%0d expected valid=0 occ=0", outBus.valid, occupancy);
    else passCount++;
  endtask

  task automatic test_identity_max();
    logic [127:0] w, got;
    logic [3:0]   gotAmt;
    int           lat;
    for (int i = 0; i < 16; i++) w[8*i +: 8] = 8'(i);
    sendOne(w, 4'd0, got, gotAmt, lat);
    checkCount++;
    if (lat !== 4 || got !== w) $display("[TB] FAIL identity_k0: got lat=%0d %h expected lat=4 %h", lat, got, w);
    else passCount++;
    sendOne(w, 4'd15, got, gotAmt, lat);
    checkCount++;
    if (got[7:0] !== 8'h0F || got[15:8] !== 8'h00 || got[127:120] !== 8'h0E)
      $display("[TB] FAIL max_k15_lanes: got l0=%h l1=%h l15=%h expected 0f 00 0e", got[7:0], got[15:8], got[127:120]);
    else passCount++;
    checkCount++;
    if (got !== refUnrotate(w, 15) || gotAmt !== 4'd15)
      $display("[TB] FAIL max_k15_word: got %h amt=%0d expected %h amt=15", got, gotAmt, refUnrotate(w, 15));
    else passCount++;
  endtask

  task automatic test_streaming();
    logic [127:0] words [16];
    logic         ov [24];
    logic [127:0] od [24];
    logic [3:0]   oa [24];
    for (int i = 0; i < 16; i++) words[i] = randWord();
    outBus.ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (c < 16) begin
        inBus.valid = 1'b1;
        inBus.data  = words[c];
        inBus.amt   = 4'(c);
        #1;
        checkCount++;
        if (inBus.ready !== 1'b1) $display("[TB] FAIL stream_in_ready[%0d]: got %b expected 1", c, inBus.ready);
        else passCount++;
      end else begin
        idleInputs();
      end
      cycle();
      ov[c] = outBus.valid;
      od[c] = outBus.data;
      oa[c] = outBus.amt;
    end
    for (int c = 0; c < 24; c++) begin
      checkCount++;
      if (c >= 3 && c < 19) begin
        if (ov[c] !== 1'b1 || od[c] !== refUnrotate(words[c-3], c-3) || oa[c] !== 4'(c-3))
          $display("[TB] FAIL stream_out[%0d]: got v=%b %h amt=%0d expected v=1 %h amt=%0d",
                   c, ov[c], od[c], oa[c], refUnrotate(words[c-3], c-3), c-3);
        else passCount++;
      end else begin
        if (ov[c] !== 1'b0) $display("[TB] FAIL stream_idle[%0d]: got valid=%b expected 0", c, ov[c]);
        else passCount++;
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [127:0] words [6];
    logic [3:0]   ks [6];
    logic [127:0] held;
    int           accepted = 0, emitted = 0, inflight = 0;
    logic         inFire, outFire;
    for (int i = 0; i < 6; i++) begin
      words[i] = randWord();
      ks[i] = 4'($urandom);
    end
    outBus.ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      inBus.valid = 1'b1;
      inBus.data  = words[accepted];
      inBus.amt   = ks[accepted];
      #1;
      checkCount++;
      if (inBus.ready !== (inflight < SW)) $display("[TB] FAIL bp_fill_ready[%0d]: got %b expected %b", c, inBus.ready, inflight < SW);
      else passCount++;
      inFire = inBus.ready;
      cycle();
      if (inFire) begin
        accepted++;
        inflight++;
      end
    end
    checkCount++;
    if (accepted !== 4) $display("[TB] FAIL bp_accepted: got %0d expected 4", accepted);
    else passCount++;
    checkCount++;
    if (inBus.ready !== 1'b0 || occupancy !== 5'd4)
      $display("[TB] FAIL bp_full: got ready=%b occ=%0d expected ready=0 occ=4", inBus.ready, occupancy);
    else passCount++;
    held = outBus.data;
    checkCount++;
    if (outBus.valid !== 1'b1 || held !== refUnrotate(words[0], ks[0]))
      $display("[TB] FAIL bp_head: got v=%b %h expected v=1 %h", outBus.valid, held, refUnrotate(words[0], ks[0]));
    else passCount++;
    for (int c = 0; c < 3; c++) begin
      cycle();
      checkCount++;
      if (outBus.data !== held || outBus.amt !== ks[0])
        $display("[TB] FAIL bp_stall[%0d]: got %h amt=%0d expected %h amt=%0d", c, outBus.data, outBus.amt, held, ks[0]);
      else passCount++;
    end
    outBus.ready = 1'b1;
    for (int c = 0; c < 40 && emitted < 6; c++) begin
      if (accepted < 6) begin
        inBus.valid = 1'b1;
        inBus.data  = words[accepted];
        inBus.amt   = ks[accepted];
      end else begin
        idleInputs();
      end
      #1;
      checkCount++;
      if (inBus.ready !== 1'b1) $display("[TB] FAIL bp_drain_ready[%0d]: got %b expected 1", c, inBus.ready);
      else passCount++;
      inFire  = inBus.valid && inBus.ready;
      outFire = outBus.valid;
      if (outFire) begin
        checkCount++;
        if (outBus.data !== refUnrotate(words[emitted], ks[emitted]))
          $display("[TB] FAIL bp_drain_word[%0d]: got %h expected %h", emitted, outBus.data, refUnrotate(words[emitted], ks[emitted]));
        else passCount++;
      end
      cycle();
      if (inFire) accepted++;
      if (outFire) emitted++;
    end
    checkCount++;
    if (emitted !== 6 || accepted !== 6 || occupancy !== '0)
      $display("[TB] FAIL bp_complete: got emitted=%0d accepted=%0d occ=%0d expected 6 6 0", emitted, accepted, occupancy);
    else passCount++;
  endtask

  task automatic test_round_trip();
    logic [127:0] expQ [$];
    logic [3:0]   amtQ [$];
    logic [127:0] orig;
    logic [3:0]   k;
    logic         pending = 1'b0, inFire, outFire;
    int           sent = 0, recv = 0, inflight = 0, cyc = 0;
    while (recv < 1000 && cyc < 20000) begin
      if (!pending && sent < 1000 && $urandom_range(9) < 7) begin
        orig = randWord();
        k = 4'($urandom);
        pending = 1'b1;
      end
      if (pending) begin
        inBus.valid = 1'b1;
        inBus.data  = refRotate(orig, k);
        inBus.amt   = k;
      end else begin
        idleInputs();
      end
      outBus.ready = ($urandom_range(9) < 7);
      #1;
      checkCount++;
      if (inBus.ready !== (outBus.ready || inflight < SW))
        $display("[TB] FAIL rt_in_ready[%0d]: got %b expected %b", cyc, inBus.ready, outBus.ready || inflight < SW);
      else passCount++;
      inFire  = inBus.valid && inBus.ready;
      outFire = outBus.valid && outBus.ready;
      if (outFire) begin
        checkCount++;
        if (expQ.size() == 0) $display("[TB] FAIL rt_unexpected[%0d]: got %h expected no word", cyc, outBus.data);
        else if (outBus.data !== expQ[0] || outBus.amt !== amtQ[0])
          $display("[TB] FAIL rt_word[%0d]: got %h amt=%0d expected %h amt=%0d", recv, outBus.data, outBus.amt, expQ[0], amtQ[0]);
        else passCount++;
        if (expQ.size() != 0) begin
          void'(expQ.pop_front());
          void'(amtQ.pop_front());
        end
      end
      cycle();
      cyc++;
      if (inFire) begin
        expQ.push_back(orig);
        amtQ.push_back(k);
        pending = 1'b0;
        sent++;
        inflight++;
      end
      if (outFire) begin
        recv++;
        inflight--;
      end
      checkCount++;
      if (occupancy !== 5'(inflight)) $display("[TB] FAIL rt_occupancy[%0d]: got %0d expected %0d", cyc, occupancy, inflight);
      else passCount++;
    end
    checkCount++;
    if (recv !== 1000) $display("[TB] FAIL rt_count: got %0d expected 1000", recv);
    else passCount++;
  endtask

  task automatic test_reset_midflight();
    logic staleSeen = 1'b0;
    outBus.ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      inBus.valid = 1'b1;
      inBus.data  = randWord();
      inBus.amt   = 4'($urandom);
      cycle();
    end
    idleInputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checkCount++;
    if (outBus.valid !== 1'b0 || outBus.data !== '0 || occupancy !== '0)
      $display("[TB] FAIL midreset_clear: got v=%b %h occ=%0d expected v=0 0 occ=0", outBus.valid, outBus.data, occupancy);
    else passCount++;
    #1;
    checkCount++;
    if (inBus.ready !== 1'b1) $display("[TB] FAIL midreset_in_ready: got %b expected 1", inBus.ready);
    else passCount++;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (outBus.valid !== 1'b0) staleSeen = 1'b1;
    end
    checkCount++;
    if (staleSeen !== 1'b0) $display("[TB] FAIL midreset_stale: got stale word=%b expected 0", staleSeen);
    else passCount++;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idleInputs();
    outBus.ready = 1'b0;
    test_reset();
    test_basic_rotate();
    test_identity_max();
    test_streaming();
    test_back_pressure();
    test_round_trip();
    test_reset_midflight();
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/byte_unrotator_pipe.md
Name: byte_unrotator_pipe

Overview:
- Pipelined, elastic byte-lane rotator that undoes the forward byte-rotation of the barrel-shifter datapath.
- Rotates an N-byte word toward lane 0 by a per-transaction amount k (0..N-1): output lane j = input lane (j+k) mod N.
- Built as log2(N) registered stages. Stage s rotates by 2^s lanes when bit s of k is set.
- Valid/ready handshake on both sides gives full throughput and lossless back-pressure. It sits at the receive end of the shifter datapath.

Parameters:
- N, 16: number of byte lanes; must be a power of 2, N >= 2.
- SW, $clog2(N): amount width and stage count; derived, must not be overridden.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts the input word this cycle.
- in_data  input  8*N  input word; lane i = in_data[8*i +: 8].
- in_amt  input  SW  rotate amount k.
- out_valid  output  1  output word present.
- out_ready  input  1  downstream accepts the output word.
- out_data  output  8*N  rotated word.
- out_amt  output  SW  k that travelled with out_data.
- occupancy  output  SW+1  number of valid stage registers (0..SW).

Behaviour:
- Reset (clk edge with reset=1):
  - All stage valid bits, data regs and amt regs clear to 0.
  - out_valid=0, out_data=0, out_amt=0, occupancy=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Reset mid-operation discards all in-flight words; nothing is emitted afterwards.
  - Reset takes priority over every handshake in the same cycle.
- Stage structure:
  - Stage registers R0..R(SW-1); each holds valid, data and amt.
  - R(SW-1) drives out_valid, out_data and out_amt directly, with no combinational path from in_data.
- Stage s input:
  - Input is in_* for s=0, else R(s-1).
  - If amt bit s = 1, lane j takes input lane (j + 2^s) mod N; otherwise it passes unchanged.
  - amt is forwarded unmodified.
- Stage ready:
  - ready(SW) = out_ready.
  - ready(s) = !R(s).valid || ready(s+1).
  - in_ready = ready(0).
  - This is a combinational ready chain; no bubble is required between back-to-back words.
- Stage load:
  - R(s) loads when ready(s)=1.
  - On load, R(s).valid takes the upstream valid: in_valid for s=0, else R(s-1).valid.
  - Data and amt load only when the upstream valid is 1; otherwise they hold.
- Transfers: a word is transferred when in_valid && in_ready at input, or out_valid && out_ready at output.
- Latency and throughput:
  - With out_ready held 1, a word accepted at edge t appears with out_valid=1 after edge t+SW-1, i.e. SW cycles of latency.
  - Throughput is one word per cycle.
- Capacity: SW words. With out_ready=0, in_ready falls only once all SW stages are valid.
- Stall: while out_valid=1 and out_ready=0, out_data and out_amt hold stable.
- Rotation semantics:
  - The composition of the SW stages is an exact rotation by k.
  - k=0 is identity.
  - Rotation wraps modulo N; no byte is lost or duplicated.
- occupancy:
  - Registered count of set valid bits, updated on the same edge as the valid bits.
  - Simultaneous accept and emit leaves it unchanged.
- X-safety: in_data and in_amt are ignored while in_valid=0.

Test Plan:
- Basic rotate:
  - Stimulus: N=16, out_ready=1; one word with lane i = 0x00+i, k=3.
  - Required: exactly 4 cycles later out_valid=1; lane0=0x03, lane12=0x0F, lane13=0x00, lane15=0x02; out_amt=3.
- Identity and max amount, same input word:
  - k=0: out equals in.
  - k=15: lane0=0x0F, lane1=0x00, lane15=0x0E.
- Streaming:
  - Stimulus: 16 back-to-back words with k=0..15, out_ready=1.
  - Required: 16 consecutive output cycles in order, each rotated correctly; in_ready stays 1 throughout.
- Back-pressure:
  - Stimulus: out_ready=0, offer 6 words.
  - Required: exactly 4 accepted, in_ready=0 afterwards, occupancy=4, out_data stable.
  - Then out_ready=1: the 4 words drain in order and the remaining 2 are accepted.
- Round trip:
  - Stimulus: random 16-byte words rotated by the forward shifter chain (lane j takes lane (j-k) mod 16), fed into this block with the same k, for 1000 random k values.
  - Required: every output equals the original word.
- Reset mid-flight:
  - Stimulus: 3 words in flight, assert reset for 1 cycle.
  - Required: next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1; no stale word appears later.
